// File: rtl/gpio_irq_pkg.sv
// -----------------------------------------------------------------------------
// gpio_irq_pkg
// Shared constants for the cape GPIO interrupt controller:
//   - APB address width and register byte offsets
//   - debounce count threshold (number of ticks minus one that a change
//     must persist before the debounced state follows it)
// -----------------------------------------------------------------------------
package gpio_irq_pkg;

    localparam int APB_AW = 8;

    localparam logic [APB_AW-1:0] ENABLE_OFF     = 8'h00;
    localparam logic [APB_AW-1:0] RISE_EN_OFF    = 8'h04;
    localparam logic [APB_AW-1:0] FALL_EN_OFF    = 8'h08;
    localparam logic [APB_AW-1:0] PENDING_OFF    = 8'h0C;
    localparam logic [APB_AW-1:0] DEB_PERIOD_OFF = 8'h10;
    localparam logic [APB_AW-1:0] LEVEL_OFF      = 8'h14;
    localparam logic [APB_AW-1:0] LEVEL_MODE_OFF = 8'h18;

    // dcnt value at which the next tick commits the new level (3 ticks total)
    localparam logic [1:0] DEB_CNT_MAX = 2'd2;

endpackage

// File: rtl/gpio_debounce.sv
// -----------------------------------------------------------------------------
// gpio_debounce
// One GPIO pin: 2-flop synchroniser, tick-based debouncer and edge detector.
// The debounced level only follows the synchronised input once the difference
// has persisted across three consecutive ticks; any cycle where the inputs
// agree again restarts the count.
//
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   i_tick   debounce sample strobe from the shared prescaler
//   i_raw    raw asynchronous pin input
//   o_deb    debounced level
//   o_rise   one-cycle pulse when o_deb goes 0->1
//   o_fall   one-cycle pulse when o_deb goes 1->0
// -----------------------------------------------------------------------------
module gpio_debounce
    import gpio_irq_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_deb,
    output logic o_rise,
    output logic o_fall
);

    logic       r_sync1;
    logic       r_sync2;
    logic [1:0] r_dcnt;
    logic       r_deb;
    logic       r_deb_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dcnt  <= 2'd0;
            r_deb   <= 1'b0;
            r_deb_q <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_deb_q <= r_deb;
            if (r_sync2 == r_deb) begin
                r_dcnt <= 2'd0;
            end else if (i_tick) begin
                if (r_dcnt == DEB_CNT_MAX) begin
                    r_deb  <= r_sync2;
                    r_dcnt <= 2'd0;
                end else begin
                    r_dcnt <= r_dcnt + 2'd1;
                end
            end
        end
    end

    assign o_deb  = r_deb;
    assign o_rise = r_deb & ~r_deb_q;
    assign o_fall = ~r_deb & r_deb_q;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_irq_ctrl
// Cape GPIO interrupt controller. Each input pin is synchronised, debounced
// and edge-detected; enabled edges latch a PENDING bit, and PENDING & ENABLE
// drives a registered level interrupt per pin. Configured through a
// zero-wait-state APB3 slave.
//
// Optional build macro: GPIO_IRQ_LEVEL_MODE_EN
//   Adds LEVEL_MODE at 0x18. Pins in level mode re-assert PENDING every cycle
//   the debounced level matches RISE_EN (high) / FALL_EN (low).
//   Without the macro 0x18 reads 0, ignores writes, and all pins are edge mode.
//
// Ports:
//   PCLK, PRESETN            clock, asynchronous active-low reset
//   psel/penable/pwrite      APB control
//   paddr[7:0], pwdata[31:0] APB address (bits [1:0] ignored) / write data
//   prdata[31:0]             combinational read data (0 when not reading)
//   gpio_in[NUM_IN-1:0]      raw asynchronous GPIO inputs
//   int_out[NUM_IN-1:0]      per-pin active-high interrupt level
// -----------------------------------------------------------------------------
module gpio_irq_ctrl
    import gpio_irq_pkg::*;
#(
    parameter int NUM_IN = 8,
    parameter int DEB_W  = 16
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [APB_AW-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    input  logic [NUM_IN-1:0] gpio_in,
    output logic [NUM_IN-1:0] int_out
);

    logic [NUM_IN-1:0] r_enable;
    logic [NUM_IN-1:0] r_rise_en;
    logic [NUM_IN-1:0] r_fall_en;
    logic [NUM_IN-1:0] r_pending;
    logic [NUM_IN-1:0] r_int;
    logic [DEB_W-1:0]  r_deb_period;
    logic [DEB_W-1:0]  r_presc;
`ifdef GPIO_IRQ_LEVEL_MODE_EN
    logic [NUM_IN-1:0] r_level_mode;
`endif

    logic [APB_AW-1:0] w_addr;
    logic              w_wr;
    logic              w_rd;
    logic              w_tick;
    logic [NUM_IN-1:0] w_deb;
    logic [NUM_IN-1:0] w_rise;
    logic [NUM_IN-1:0] w_fall;
    logic [NUM_IN-1:0] w_set;
    logic [NUM_IN-1:0] w_clr;
    logic [31:0]       w_rdata;
    logic              w_unused;

    // Word-aligned decode: the two byte-lane bits never select a register.
    assign w_addr   = {paddr[APB_AW-1:2], 2'b00};
    assign w_wr     = psel & penable & pwrite;
    assign w_rd     = psel & ~pwrite;
    assign w_unused = &{1'b0, paddr[1:0], pwdata};

    // ------------------------------------------------------------------
    // Debounce tick prescaler: counts 0..DEB_PERIOD, tick on the last count.
    // A period write restarts it so the new period takes effect cleanly.
    // ------------------------------------------------------------------
    assign w_tick = (r_presc == r_deb_period);

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_presc <= '0;
        end else if (w_wr && (w_addr == DEB_PERIOD_OFF)) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-pin front end and pending-set logic
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_pin
            gpio_debounce u_deb (
                .i_clk   (PCLK),
                .i_rst_n (PRESETN),
                .i_tick  (w_tick),
                .i_raw   (gpio_in[gi]),
                .o_deb   (w_deb[gi]),
                .o_rise  (w_rise[gi]),
                .o_fall  (w_fall[gi])
            );
`ifdef GPIO_IRQ_LEVEL_MODE_EN
            assign w_set[gi] = r_level_mode[gi]
                ? ((w_deb[gi] & r_rise_en[gi]) | (~w_deb[gi] & r_fall_en[gi]))
                : ((w_rise[gi] & r_rise_en[gi]) | (w_fall[gi] & r_fall_en[gi]));
`else
            assign w_set[gi] = (w_rise[gi] & r_rise_en[gi]) |
                               (w_fall[gi] & r_fall_en[gi]);
`endif
        end
    endgenerate

    assign w_clr = (w_wr && (w_addr == PENDING_OFF)) ? pwdata[NUM_IN-1:0] : '0;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_enable     <= '0;
            r_rise_en    <= '0;
            r_fall_en    <= '0;
            r_deb_period <= '0;
        end else if (w_wr) begin
            case (w_addr)
                ENABLE_OFF:     r_enable     <= pwdata[NUM_IN-1:0];
                RISE_EN_OFF:    r_rise_en    <= pwdata[NUM_IN-1:0];
                FALL_EN_OFF:    r_fall_en    <= pwdata[NUM_IN-1:0];
                DEB_PERIOD_OFF: r_deb_period <= pwdata[DEB_W-1:0];
                default: ;
            endcase
        end
    end

`ifdef GPIO_IRQ_LEVEL_MODE_EN
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_level_mode <= '0;
        end else if (w_wr && (w_addr == LEVEL_MODE_OFF)) begin
            r_level_mode <= pwdata[NUM_IN-1:0];
        end
    end
`endif

    // Set has priority over a simultaneous W1C so no event is ever lost.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_pending <= '0;
            r_int     <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
            r_int     <= r_pending & r_enable;
        end
    end

    assign int_out = r_int;

    // ------------------------------------------------------------------
    // Read mux (combinational, zero wait states)
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (w_addr)
                ENABLE_OFF:     w_rdata[NUM_IN-1:0] = r_enable;
                RISE_EN_OFF:    w_rdata[NUM_IN-1:0] = r_rise_en;
                FALL_EN_OFF:    w_rdata[NUM_IN-1:0] = r_fall_en;
                PENDING_OFF:    w_rdata[NUM_IN-1:0] = r_pending;
                DEB_PERIOD_OFF: w_rdata[DEB_W-1:0]  = r_deb_period;
                LEVEL_OFF:      w_rdata[NUM_IN-1:0] = w_deb;
`ifdef GPIO_IRQ_LEVEL_MODE_EN
                LEVEL_MODE_OFF: w_rdata[NUM_IN-1:0] = r_level_mode;
`endif
                default: ;
            endcase
        end
    end

    assign prdata = w_rdata;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpio_irq_ctrl
// Self-checking bench for gpio_irq_ctrl (NUM_IN=8, DEB_W=16): directed
// scenarios plus randomized pin activity checked against a window-based
// reference model of the debounce/pending/interrupt rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gpio_irq_ctrl;

    localparam logic [7:0] A_ENABLE  = 8'h00;
    localparam logic [7:0] A_RISE    = 8'h04;
    localparam logic [7:0] A_FALL    = 8'h08;
    localparam logic [7:0] A_PENDING = 8'h0C;
    localparam logic [7:0] A_DEB     = 8'h10;
    localparam logic [7:0] A_LEVEL   = 8'h14;
    localparam logic [7:0] A_LMODE   = 8'h18;
    localparam int         RN        = 300;

    logic        PCLK = 1'b0;
    logic        PRESETN = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [7:0]  paddr = 8'h00;
    logic [31:0] pwdata = 32'h0;
    logic [31:0] prdata;
    logic [7:0]  gpio_in = 8'h00;
    logic [7:0]  int_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 PCLK = ~PCLK;

    gpio_irq_ctrl #(.NUM_IN(8), .DEB_W(16)) dut (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .gpio_in (gpio_in),
        .int_out (int_out)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got hang, required finish");
        $fatal(1, "watchdog");
    end

    // Called off-edge; the write happens on the second rising edge and the
    // task returns 1 ns after that edge.
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        @(posedge PCLK);
        #1 penable = 1'b1;
        @(posedge PCLK);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        $display("[TB] apb write addr=%02h data=%08h", a, d);
    endtask

    // Combinational read; consumes 1 ns and must not straddle a clock edge.
    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        #1 d = prdata;
        psel = 1'b0;
    endtask

    task automatic do_reset;
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; gpio_in = 0;
        PRESETN = 1'b0;
        repeat (2) @(posedge PCLK);
        #1 PRESETN = 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic [7:0]  addrs [7];
        addrs = '{A_ENABLE, A_RISE, A_FALL, A_PENDING, A_DEB, A_LEVEL, A_LMODE};
        do_reset;
        @(posedge PCLK); #1;
        for (int i = 0; i < 7; i++) begin
            apb_read(addrs[i], d);
            n_tests++;
            if (d !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read addr=%02h got %08h required 00000000", addrs[i], d);
            end
        end
        n_tests++;
        if (int_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_int_out got %02h required 00", int_out);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_rise;
        logic [31:0] d;
        do_reset;
        apb_write(A_ENABLE, 32'h01);
        apb_write(A_RISE, 32'h01);
        gpio_in[0] = 1'b1;
        repeat (4) @(posedge PCLK);
        #1 apb_read(A_LEVEL, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL rise_level_early got %08h required 00000000", d);
        end
        @(posedge PCLK); #1 apb_read(A_LEVEL, d);
        n_tests++;
        if (d !== 32'h1) begin
            n_fail++;
            $display("FAIL rise_level_5cyc got %08h required 00000001", d);
        end
        apb_read(A_PENDING, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL rise_pending_early got %08h required 00000000", d);
        end
        @(posedge PCLK); #1 apb_read(A_PENDING, d);
        n_tests++;
        if (d !== 32'h1) begin
            n_fail++;
            $display("FAIL rise_pending got %08h required 00000001", d);
        end
        n_tests++;
        if (int_out !== 8'h00) begin
            n_fail++;
            $display("FAIL rise_int_early got %02h required 00", int_out);
        end
        @(posedge PCLK); #1;
        n_tests++;
        if (int_out !== 8'h01) begin
            n_fail++;
            $display("FAIL rise_int got %02h required 01", int_out);
        end
        $display("[TB] test_rise done");
    endtask

    task automatic test_glitch;
        logic [31:0] d;
        logic        r;
        do_reset;
        apb_write(A_RISE, 32'h08);
        apb_write(A_DEB, 32'd9);
        // With the prescaler restarted by the write, a 25-cycle pulse here
        // only spans two ticks, so it must be rejected.
        gpio_in[3] = 1'b1;
        repeat (25) @(posedge PCLK);
        #1 gpio_in[3] = 1'b0;
        repeat (40) @(posedge PCLK);
        #1 apb_read(A_LEVEL, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL glitch_level got %08h required 00000000", d);
        end
        apb_read(A_PENDING, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL glitch_pending got %08h required 00000000", d);
        end
        r = 1'($urandom_range(0, 1));
        apb_write(A_RISE, {28'h0, r, 3'b000});
        gpio_in[3] = 1'b1;
        repeat (40) @(posedge PCLK);
        #1 apb_read(A_LEVEL, d);
        n_tests++;
        if (d !== 32'h08) begin
            n_fail++;
            $display("FAIL hold_level got %08h required 00000008", d);
        end
        apb_read(A_PENDING, d);
        n_tests++;
        if (d !== {28'h0, r, 3'b000}) begin
            n_fail++;
            $display("FAIL hold_pending got %08h required %08h", d, {28'h0, r, 3'b000});
        end
        $display("[TB] test_glitch done (rise_en3=%0d)", r);
    endtask

    task automatic test_w1c_collision;
        logic [31:0] d;
        do_reset;
        apb_write(A_FALL, 32'h04);
        apb_write(A_ENABLE, 32'h04);
        gpio_in[2] = 1'b1;
        repeat (10) @(posedge PCLK);
        #1 gpio_in[2] = 1'b0;
        // Debounced fall commits 5 edges later; pending sets on the 6th,
        // which is exactly the write edge of the W1C below.
        repeat (4) @(posedge PCLK);
        #1 apb_read(A_LEVEL, d);
        n_tests++;
        if (d !== 32'h04) begin
            n_fail++;
            $display("FAIL w1c_level_before got %08h required 00000004", d);
        end
        apb_write(A_PENDING, 32'h04);
        apb_read(A_PENDING, d);
        n_tests++;
        if (d !== 32'h04) begin
            n_fail++;
            $display("FAIL w1c_collision_pending got %08h required 00000004", d);
        end
        @(posedge PCLK); #1;
        n_tests++;
        if (int_out !== 8'h04) begin
            n_fail++;
            $display("FAIL w1c_int_set got %02h required 04", int_out);
        end
        apb_write(A_PENDING, 32'h04);
        apb_read(A_PENDING, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL w1c_clear_pending got %08h required 00000000", d);
        end
        @(posedge PCLK); #1;
        n_tests++;
        if (int_out !== 8'h00) begin
            n_fail++;
            $display("FAIL w1c_int_clear got %02h required 00", int_out);
        end
        $display("[TB] test_w1c_collision done");
    endtask

    task automatic test_mask;
        logic [31:0] d;
        do_reset;
        apb_write(A_FALL, 32'hFF);
        gpio_in[7] = 1'b1;
        repeat (10) @(posedge PCLK);
        #1 apb_read(A_PENDING, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL mask_no_rise_pending got %08h required 00000000", d);
        end
        gpio_in[7] = 1'b0;
        repeat (10) @(posedge PCLK);
        #1 apb_read(A_PENDING, d);
        n_tests++;
        if (d !== 32'h80) begin
            n_fail++;
            $display("FAIL mask_pending got %08h required 00000080", d);
        end
        n_tests++;
        if (int_out !== 8'h00) begin
            n_fail++;
            $display("FAIL mask_int_masked got %02h required 00", int_out);
        end
        apb_write(A_ENABLE, 32'h80);
        n_tests++;
        if (int_out !== 8'h00) begin
            n_fail++;
            $display("FAIL mask_int_same_cycle got %02h required 00", int_out);
        end
        @(posedge PCLK); #1;
        n_tests++;
        if (int_out !== 8'h80) begin
            n_fail++;
            $display("FAIL mask_int_enabled got %02h required 80", int_out);
        end
        apb_write(A_ENABLE, 32'h00);
        @(posedge PCLK); #1;
        n_tests++;
        if (int_out !== 8'h00) begin
            n_fail++;
            $display("FAIL mask_int_disabled got %02h required 00", int_out);
        end
        apb_read(A_PENDING, d);
        n_tests++;
        if (d !== 32'h80) begin
            n_fail++;
            $display("FAIL mask_pending_retained got %08h required 00000080", d);
        end
        $display("[TB] test_mask done");
    endtask

    task automatic test_midreset;
        logic [31:0] d;
        do_reset;
        apb_write(A_RISE, 32'h0F);
        apb_write(A_ENABLE, 32'h0F);
        gpio_in = 8'h0F;
        repeat (10) @(posedge PCLK);
        #1 apb_read(A_PENDING, d);
        n_tests++;
        if (d !== 32'h0F) begin
            n_fail++;
            $display("FAIL midrst_pending_before got %08h required 0000000f", d);
        end
        n_tests++;
        if (int_out !== 8'h0F) begin
            n_fail++;
            $display("FAIL midrst_int_before got %02h required 0f", int_out);
        end
        #2 PRESETN = 1'b0;
        #1;
        n_tests++;
        if (int_out !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_int_async got %02h required 00", int_out);
        end
        apb_read(A_PENDING, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_pending_async got %08h required 00000000", d);
        end
        gpio_in = 8'h00;
        @(posedge PCLK); @(posedge PCLK);
        #1 PRESETN = 1'b1;
        apb_read(A_ENABLE, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_enable_after got %08h required 00000000", d);
        end
        apb_read(A_RISE, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_rise_after got %08h required 00000000", d);
        end
        apb_read(A_LEVEL, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_level_after got %08h required 00000000", d);
        end
        $display("[TB] test_midreset done");
    endtask

    // Reference model rule: on a tick, the debounced bit flips if the
    // synchronised input (raw delayed two edges) disagreed with it on every
    // edge from two ticks earlier up to and including this tick.
    task automatic test_random(input int p);
        logic [7:0]  raw_at [0:RN];
        logic [7:0]  mdeb   [0:RN];
        logic [7:0]  mpend  [0:RN];
        logic [7:0]  en, re, fe, cur, d1, d2, set, exp_int;
        logic [31:0] exp_rd;
        logic        sel, tick, flip, s;
        int          lo, idx;
        do_reset;
        en = 8'($urandom);
        re = 8'($urandom);
        fe = 8'($urandom);
        apb_write(A_ENABLE, {24'h0, en});
        apb_write(A_RISE, {24'h0, re});
        apb_write(A_FALL, {24'h0, fe});
        apb_write(A_DEB, p);
        for (int i = 0; i <= RN; i++) begin
            raw_at[i] = 8'h00; mdeb[i] = 8'h00; mpend[i] = 8'h00;
        end
        cur = 8'h00;
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0;
        for (int n = 1; n <= RN; n++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 3 * p + 6) == 0) cur[b] = ~cur[b];
            end
            gpio_in = cur;
            sel = 1'($urandom_range(0, 1));
            paddr = sel ? A_LEVEL : A_PENDING;
            @(posedge PCLK);
            raw_at[n] = cur;
            tick = (((n - 1) % (p + 1)) == p);
            mdeb[n] = mdeb[n-1];
            if (tick) begin
                for (int b = 0; b < 8; b++) begin
                    flip = 1'b1;
                    lo = n - 2 * (p + 1);
                    for (int m = lo; m <= n; m++) begin
                        idx = m - 2;
                        s = (idx <= 0) ? 1'b0 : raw_at[idx][b];
                        if (s == mdeb[n-1][b]) flip = 1'b0;
                    end
                    if (flip) mdeb[n][b] = ~mdeb[n-1][b];
                end
            end
            d1 = mdeb[n-1];
            d2 = (n >= 2) ? mdeb[n-2] : 8'h00;
            set = (d1 & ~d2 & re) | (~d1 & d2 & fe);
            mpend[n] = mpend[n-1] | set;
            exp_int = mpend[n-1] & en;
            #1;
            exp_rd = sel ? {24'h0, mdeb[n]} : {24'h0, mpend[n]};
            n_tests++;
            if (prdata !== exp_rd) begin
                n_fail++;
                $display("FAIL rand_p%0d_%s cyc=%0d got %08h required %08h",
                         p, sel ? "level" : "pending", n, prdata, exp_rd);
            end
            n_tests++;
            if (int_out !== exp_int) begin
                n_fail++;
                $display("FAIL rand_p%0d_int cyc=%0d got %02h required %02h",
                         p, n, int_out, exp_int);
            end
        end
        psel = 1'b0;
        $display("[TB] test_random period=%0d en=%02h rise=%02h fall=%02h done", p, en, re, fe);
    endtask

    initial begin
        test_reset;
        test_rise;
        test_glitch;
        test_w1c_collision;
        test_mask;
        test_midreset;
        test_random(0);
        test_random(1);
        test_random(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
